// File: rtl/mips8_pkg.sv
// mips8_pkg: definitions shared by the 8-bit MIPS core front end.
//   - fetch FSM state encoding
//   - instruction field positions, also used by the decoder and the
//     sign_extend wiring
//   - instruction and memory byte widths
package mips8_pkg;

  localparam int INSTR_W = 16;
  localparam int BYTE_W  = 8;

  // Field positions inside the 16-bit instruction word
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RS_HI  = 11;
  localparam int RS_LO  = 9;
  localparam int RT_HI  = 8;
  localparam int RT_LO  = 6;
  localparam int IMM_HI = 5;
  localparam int IMM_LO = 0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH_HI = 2'd1,
    FETCH_LO = 2'd2
  } fetch_state_e;

endpackage : mips8_pkg

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: multicycle instruction fetch for the 8-bit MIPS core.
// Reads a 16-bit big-endian instruction as two bytes over an 8-bit
// req/ack memory port, holds it in the instruction register and slices it
// into fields. Owns the PC (with a load port for jumps/branches) and aborts
// a fetch whose memory does not answer within TIMEOUT cycles.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start               one-cycle fetch request (ignored while busy)
//   pc_we, pc_in        PC load; aborts an in-progress fetch
//   mem_req, mem_addr   byte read request / address (= pc)
//   mem_rdata, mem_ack  read data, valid in the one-cycle ack
//   pc                  current PC
//   instr               instruction register
//   opcode, rs, rt, imm6  field slices of instr
//   instr_valid         one-cycle pulse after a new instruction is latched
//   busy                fetch in progress
//   fetch_err           sticky timeout flag, cleared by start or reset
module instr_fetch_unit
  import mips8_pkg::*;
#(
  parameter logic [BYTE_W-1:0] RESET_PC = 8'h00,
  parameter int unsigned       TIMEOUT  = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               pc_we,
  input  logic [BYTE_W-1:0]  pc_in,
  output logic               mem_req,
  output logic [BYTE_W-1:0]  mem_addr,
  input  logic [BYTE_W-1:0]  mem_rdata,
  input  logic               mem_ack,
  output logic [BYTE_W-1:0]  pc,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode,
  output logic [2:0]         rs,
  output logic [2:0]         rt,
  output logic [5:0]         imm6,
  output logic               instr_valid,
  output logic               busy,
  output logic               fetch_err
);

  // The abort fires in the cycle the counter would reach TIMEOUT, so
  // mem_req is held for at most TIMEOUT cycles without an ack.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  fetch_state_e       state_q, state_d;
  logic [BYTE_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [BYTE_W-1:0]  hi_q, hi_d;
  logic [7:0]         wait_q, wait_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;

  logic timeout_hit;
  assign timeout_hit = (wait_q == WAIT_LAST);

  // NOTE: every signal written here gets its default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    hi_d    = hi_q;
    wait_d  = wait_q;
    valid_d = 1'b0;
    err_d   = err_q;

    if (pc_we) begin
      // PC load wins over everything: any fetch in flight is dropped. In
      // IDLE a simultaneous start fetches from the freshly loaded PC.
      pc_d   = pc_in;
      wait_d = '0;
      if (state_q == IDLE && start) begin
        state_d = FETCH_HI;
        err_d   = 1'b0;
      end else begin
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = FETCH_HI;
            err_d   = 1'b0;
            wait_d  = '0;
          end
        end
        FETCH_HI: begin
          if (mem_ack) begin
            hi_d    = mem_rdata;
            pc_d    = pc_q + 8'd1;
            wait_d  = '0;
            state_d = FETCH_LO;
          end else if (timeout_hit) begin
            err_d   = 1'b1;
            wait_d  = '0;
            state_d = IDLE;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
        FETCH_LO: begin
          if (mem_ack) begin
            instr_d = {hi_q, mem_rdata};
            pc_d    = pc_q + 8'd1;
            valid_d = 1'b1;
            wait_d  = '0;
            state_d = IDLE;
          end else if (timeout_hit) begin
            err_d   = 1'b1;
            wait_d  = '0;
            state_d = IDLE;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      hi_q    <= '0;
      wait_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      hi_q    <= hi_d;
      wait_q  <= wait_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign mem_req     = busy;
  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign fetch_err   = err_q;

  assign opcode = instr_q[OPC_HI:OPC_LO];
  assign rs     = instr_q[RS_HI:RS_LO];
  assign rt     = instr_q[RT_HI:RT_LO];
  assign imm6   = instr_q[IMM_HI:IMM_LO];

endmodule : instr_fetch_unit

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Multicycle instruction fetch stage for the 8-bit MIPS core. It reads 16-bit instructions as two bytes over an 8-bit memory handshake and holds the assembled word in the instruction register. It splits the instruction into fields; the 6-bit signed immediate field feeds the sign-extension stage directly downstream. The block owns the PC, with a load port for jumps and branches.

Parameters:
RESET_PC, 8'h00, PC value after reset.
TIMEOUT, 15, maximum cycles mem_req may wait for mem_ack before the fetch aborts with an error (1..255).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  one-cycle request from control to fetch the next instruction at pc.
pc_we  in  1  load the PC from pc_in.
pc_in  in  8  new PC value for jump or branch.
mem_req  out  1  byte read request, held high until acknowledged.
mem_addr  out  8  byte address, equal to pc while mem_req is high.
mem_rdata  in  8  read data, valid in the cycle mem_ack is high.
mem_ack  in  1  read acknowledge, one cycle.
pc  out  8  current PC.
instr  out  16  instruction register.
opcode  out  4  instr[15:12].
rs  out  3  instr[11:9].
rt  out  3  instr[8:6].
imm6  out  6  instr[5:0], signed immediate for the sign extender.
instr_valid  out  1  one-cycle pulse when a new instruction is latched.
busy  out  1  high while the state is not IDLE.
fetch_err  out  1  sticky timeout flag; cleared by start or reset.

Behaviour:
- Reset values: pc=RESET_PC, instr=16'h0000, mem_req=0, instr_valid=0, fetch_err=0, busy=0, state=IDLE, wait counter=0.
- Field outputs are combinational slices of instr. They change only when instr changes.
- States:
  - IDLE: waits for start. On start, go to FETCH_HI and clear fetch_err.
  - FETCH_HI: mem_req=1, mem_addr=pc. On mem_ack, latch mem_rdata into a hi byte holding register, pc<=pc+1, go to FETCH_LO.
  - FETCH_LO: mem_req=1, mem_addr=pc. On mem_ack, instr<={hi,mem_rdata}, pc<=pc+1, instr_valid=1 in the following cycle, go to IDLE.
- Byte order is big-endian: the byte at the lower address is instr[15:8].
- PC wrap-around: pc increments modulo 256, so 8'hFF+1 gives 8'h00. An instruction may straddle the wrap, with the hi byte at FF and the lo byte at 00.
- Latency: start is registered in IDLE. The first mem_req is seen the next cycle. With zero-wait memory (ack in the same cycle as req), instr_valid occurs 3 cycles after start.
- Wait counter:
  - Counts cycles in FETCH_HI and FETCH_LO with mem_req high and no ack.
  - Resets to 0 on each ack.
  - When it reaches TIMEOUT without ack: fetch_err<=1, mem_req drops, state<=IDLE.
  - On timeout, instr and pc keep their current values; pc may already have advanced by 1 if the hi byte was taken.
- pc_we has priority over everything except reset.
  - In any state, pc<=pc_in.
  - If busy, the in-progress fetch aborts: back to IDLE, mem_req drops, instr unchanged, no instr_valid.
- Simultaneous pc_we and start in IDLE: pc loads pc_in, and the fetch starts from pc_in.
- Events ignored by design:
  - start while busy is ignored.
  - mem_ack while in IDLE is ignored.
- Reset mid-fetch forces all reset values in the next cycle.

Decomposition:
- Shared package mips8_pkg holds:
  - the state encoding (IDLE, FETCH_HI, FETCH_LO);
  - the field position constants OPC_HI/LO, RS_HI/LO, RT_HI/LO, IMM_HI/LO;
  - INSTR_W=16, BYTE_W=8.
- The field constants are shared with the decoder and sign_extend wiring.
- No sub-module is needed: the FSM, PC register and wait counter stay in one module.

Test Plan:
- Reset, then start; memory returns 8'h4A at 00 and 8'h85 at 01 with zero wait → instr=16'h4A85, opcode=4, rs=5, rt=2, imm6=6'h05, pc=02, one instr_valid pulse.
- Memory with 3 wait cycles per byte, imm6=6'b100011 (instr=16'h1263) → instr_valid occurs 9 cycles after start, imm6=6'h23, mem_addr stable while waiting.
- pc_we with pc_in=8'hFF, then start; bytes 8'hAB at FF and 8'hCD at 00 → instr=16'hABCD, pc=8'h01.
- No ack for TIMEOUT=15 cycles → fetch_err=1, mem_req=0, busy=0, instr unchanged; the next start clears fetch_err.
- pc_we=1, pc_in=8'h40 while in FETCH_LO → return to IDLE, no instr_valid, pc=40, instr keeps its previous value.
- Reset asserted mid-FETCH_HI → the next cycle shows pc=RESET_PC, mem_req=0, instr=0.
